// File: rtl/conv3x3_layer_engine.sv
// 3x3 convolution layer engine: bias + IN_CH*9 taps, one MAC per cycle, over 1-cycle read ports.
// Latency: IN_CH*9+3 cycles per output pixel (BIAS, MAC taps, DRAIN, OUTPUT), +1 DONE cycle per layer.
// Backpressure: out_valid/out_data/out_f/out_row/out_col hold in OUTPUT until out_ready; no reads while held.
//
// Ports: clk/reset (async active-low); start/busy/done control; feat/wgt/bias read ports
// (strobe + address out, data back one cycle later); out_* result stream with valid/ready.
module conv3x3_layer_engine #(
    parameter int IN_CH   = 16,
    parameter int OUT_CH  = 32,
    parameter int H       = 14,
    parameter int W       = 14,
    parameter int DATA_W  = 32,
    parameter int WGT_W   = 8,
    parameter int ACC_W   = 40,
    parameter int STRIDE  = 1,
    parameter int PAD     = 1,
    parameter int RELU_EN = 1,
    localparam int OH     = (H + 2*PAD - 3) / STRIDE + 1,
    localparam int OW     = (W + 2*PAD - 3) / STRIDE + 1,
    localparam int FA_W   = (IN_CH*H*W > 1) ? $clog2(IN_CH*H*W) : 1,
    localparam int WA_W   = $clog2(OUT_CH*IN_CH*9),
    localparam int BA_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int ROW_W  = (OH > 1) ? $clog2(OH) : 1,
    localparam int COL_W  = (OW > 1) ? $clog2(OW) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              feat_rd_en,
    output logic [FA_W-1:0]   feat_rd_addr,
    input  logic [DATA_W-1:0] feat_rd_data,
    output logic              wgt_rd_en,
    output logic [WA_W-1:0]   wgt_rd_addr,
    input  logic [WGT_W-1:0]  wgt_rd_data,
    output logic              bias_rd_en,
    output logic [BA_W-1:0]   bias_rd_addr,
    input  logic [ACC_W-1:0]  bias_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BA_W-1:0]   out_f,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic [DATA_W-1:0] out_data
);

    localparam int C_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int PW  = DATA_W + WGT_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUTPUT, S_DONE, S_WAIT_LOW
    } state_t;

    state_t state, state_nxt;

    logic [BA_W-1:0]         f;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic [C_W-1:0]          c;
    logic [1:0]              m, n;
    logic                    first_q;   // previous cycle was BIAS: bias data on the port now
    logic                    tap_q;     // previous cycle issued a tap read: product on the ports now
    logic signed [ACC_W-1:0] acc;

    int   ir, ic, faddr, waddr;
    logic tap_inb, last_tap, last_pixel;

    // Tap geometry in plain integers so negative (padding) coordinates fall out naturally.
    always_comb begin
        ir      = int'(row) * STRIDE + int'(m) - PAD;
        ic      = int'(col) * STRIDE + int'(n) - PAD;
        tap_inb = (ir >= 0) && (ir < H) && (ic >= 0) && (ic < W);
        faddr   = int'(c) * H * W + ir * W + ic;
        waddr   = int'(f) * IN_CH * 9 + int'(c) * 9 + int'(m) * 3 + int'(n);
    end

    assign last_tap   = (c == C_W'(IN_CH-1)) && (m == 2'd2) && (n == 2'd2);
    assign last_pixel = (f == BA_W'(OUT_CH-1)) && (row == ROW_W'(OH-1)) && (col == COL_W'(OW-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        bias_rd_en = 1'b0;
        feat_rd_en = 1'b0;
        wgt_rd_en  = 1'b0;
        case (state)
            S_IDLE:     if (start) state_nxt = S_BIAS;
            S_BIAS: begin
                busy       = 1'b1;
                bias_rd_en = 1'b1;
                state_nxt  = S_MAC;
            end
            S_MAC: begin
                busy       = 1'b1;
                feat_rd_en = tap_inb;   // padding taps spend the cycle but read nothing
                wgt_rd_en  = tap_inb;
                if (last_tap) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_pixel ? S_DONE : S_BIAS;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_WAIT_LOW;
            end
            S_WAIT_LOW: if (!start) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign feat_rd_addr = feat_rd_en ? FA_W'(faddr) : '0;
    assign wgt_rd_addr  = wgt_rd_en  ? WA_W'(waddr) : '0;
    assign bias_rd_addr = bias_rd_en ? f : '0;

    logic signed [PW-1:0]    feat_x, wgt_x, prod;
    logic signed [ACC_W-1:0] prod_ext;

    assign feat_x   = PW'($signed(feat_rd_data));
    assign wgt_x    = PW'($signed(wgt_rd_data));
    assign prod     = feat_x * wgt_x;   // exact: the true product fits in PW bits
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f       <= '0;
            row     <= '0;
            col     <= '0;
            c       <= '0;
            m       <= '0;
            n       <= '0;
            first_q <= 1'b0;
            tap_q   <= 1'b0;
            acc     <= '0;
        end else begin
            first_q <= (state == S_BIAS);
            tap_q   <= feat_rd_en;
            case (state)
                S_IDLE: if (start) begin
                    f   <= '0;
                    row <= '0;
                    col <= '0;
                    c   <= '0;
                    m   <= '0;
                    n   <= '0;
                end
                S_MAC: begin
                    // The last tap wraps c/m/n back to zero, ready for the next pixel.
                    if (n == 2'd2) begin
                        n <= '0;
                        if (m == 2'd2) begin
                            m <= '0;
                            c <= (c == C_W'(IN_CH-1)) ? '0 : c + C_W'(1);
                        end else begin
                            m <= m + 2'd1;
                        end
                    end else begin
                        n <= n + 2'd1;
                    end
                end
                S_OUTPUT: if (out_ready) begin
                    if (col == COL_W'(OW-1)) begin
                        col <= '0;
                        if (row == ROW_W'(OH-1)) begin
                            row <= '0;
                            f   <= (f == BA_W'(OUT_CH-1)) ? '0 : f + BA_W'(1);
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                default: ;
            endcase
            if (first_q)    acc <= $signed(bias_rd_data);
            else if (tap_q) acc <= acc + prod_ext;
        end
    end

    assign out_f   = f;
    assign out_row = row;
    assign out_col = col;

    logic signed [ACC_W-1:0] relu_v;

    always_comb begin
        relu_v = ((RELU_EN != 0) && (acc < 0)) ? '0 : acc;
        if (relu_v > SAT_MAX)      out_data = OUT_MAX;
        else if (relu_v < SAT_MIN) out_data = OUT_MIN;
        else                       out_data = relu_v[DATA_W-1:0];
    end

endmodule
